// File: rtl/ula_op_sequencer.sv
// ---------------------------------------------------------------------------
// ula_op_sequencer
//
// Operation front-end for the combinational ULA (add/sub/shift unit).
// Accepts one request at a time over a valid/ready handshake, registers the
// operands and select towards the ULA, gives the ULA a full cycle to settle,
// captures its output into an accumulator and offers the result downstream
// over a second valid/ready handshake. Chained requests take operand A from
// the accumulator so multi-step arithmetic needs no external feedback.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake
//   in_sel, in_a, in_b    operation code and operands
//   in_chain              1 = use accumulator as operand A
//   ula_a, ula_b, ula_sel registered drive into the ULA
//   ula_s                 ULA result (combinational, from the ULA)
//   out_valid / out_ready result handshake
//   out_result, out_zero  captured result and its zero flag
//   acc                   accumulator contents
//   op_count              completed (handshaken) results, wraps
// ---------------------------------------------------------------------------
module ula_op_sequencer #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_chain,
    output logic [WIDTH-1:0]     ula_a,
    output logic [WIDTH-1:0]     ula_b,
    output logic [1:0]           ula_sel,
    input  logic [WIDTH-1:0]     ula_s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_zero,
    output logic [WIDTH-1:0]     acc,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Decoded strobes from the output process, consumed by the datapath.
    logic load_en;    // request accepted this cycle
    logic capt_en;    // ULA output is settled and captured this cycle
    logic retire_en;  // downstream handshake completes this cycle

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = EXEC;
            EXEC:                state_next = CAPT;
            CAPT:                state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / strobe decode
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        load_en   = 1'b0;
        capt_en   = 1'b0;
        retire_en = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                load_en  = in_valid;
            end
            CAPT:    capt_en   = 1'b1;
            DONE:    retire_en = out_ready;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers. ula_* only load on acceptance, so they hold their
    // last values through EXEC/CAPT and beyond (no return to zero).
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ula_a      <= '0;
            ula_b      <= '0;
            ula_sel    <= '0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_valid  <= 1'b0;
            acc        <= '0;
            op_count   <= '0;
        end else begin
            if (load_en) begin
                ula_sel <= in_sel;
                ula_b   <= in_b;
                // acc here is the result of the last captured operation
                ula_a   <= in_chain ? acc : in_a;
            end
            if (capt_en) begin
                acc        <= ula_s;
                out_result <= ula_s;
                out_zero   <= (ula_s == '0);
                out_valid  <= 1'b1;
            end
            if (retire_en) begin
                out_valid <= 1'b0;
                op_count  <= op_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ula_op_sequencer
//
// Bench for ula_op_sequencer with a behavioural ULA attached. Expected
// results are pushed on acceptance and popped on each result handshake.
// ---------------------------------------------------------------------------
module tb_ula_op_sequencer;

    localparam int WIDTH     = 4;
    localparam int CNT_WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_sel;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_chain;
    logic [WIDTH-1:0]     ula_a;
    logic [WIDTH-1:0]     ula_b;
    logic [1:0]           ula_sel;
    logic [WIDTH-1:0]     ula_s;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic                 out_zero;
    logic [WIDTH-1:0]     acc;
    logic [CNT_WIDTH-1:0] op_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0]     exp_q[$];
    logic [WIDTH-1:0]     model_acc;
    logic [CNT_WIDTH-1:0] model_cnt;

    ula_op_sequencer #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_chain   (in_chain),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_sel    (ula_sel),
        .ula_s      (ula_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .acc        (acc),
        .op_count   (op_count)
    );

    // Behavioural ULA standing in for the real combinational unit.
    always_comb begin
        case (ula_sel)
            2'b00:   ula_s = ula_a + ula_b;
            2'b01:   ula_s = ula_a - ula_b;
            2'b10:   ula_s = ula_a >> ula_b;
            default: ula_s = ula_a << ula_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ula_ref(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int unsigned sum;
        case (sel)
            2'b00: begin
                sum = (int'(a) + int'(b)) % (1 << WIDTH);
                return WIDTH'(sum);
            end
            2'b01: begin
                sum = (int'(a) + (1 << WIDTH) - int'(b)) % (1 << WIDTH);
                return WIDTH'(sum);
            end
            2'b10:   return (int'(b) >= WIDTH) ? '0 : WIDTH'(int'(a) / (1 << b));
            default: return (int'(b) >= WIDTH) ? '0 : WIDTH'((int'(a) * (1 << b)) % (1 << WIDTH));
        endcase
    endfunction

    // Present a request and hold it until accepted; returns #1 after the
    // acceptance edge.
    task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic chain);
        logic             accepted;
        logic [WIDTH-1:0] e;
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
        in_chain = chain;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e = ula_ref(sel, chain ? model_acc : a, b);
                exp_q.push_back(e);
                model_acc = e;
                accepted  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) check_eq("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid; when hs is set, also let the handshake edge pass.
    task automatic wait_out(input logic hs);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check_eq("out_valid_timeout", 32'd0, 32'd1);
        if (hs) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer and handshake exclusivity monitor.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    check_eq("sb_result", 32'(out_result), 32'(e));
                    check_eq("sb_zero", 32'(out_zero), 32'(e == '0));
                    check_eq("sb_acc", 32'(acc), 32'(e));
                end
                model_cnt = model_cnt + 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_acc = '0;
        model_cnt = '0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_zero", 32'(out_zero), 32'd1);
        check_eq("rst_out_result", 32'(out_result), 32'd0);
        check_eq("rst_acc", 32'(acc), 32'd0);
        check_eq("rst_op_count", 32'(op_count), 32'd0);
        check_eq("rst_ula_a", 32'(ula_a), 32'd0);
        check_eq("rst_ula_b", 32'(ula_b), 32'd0);
        check_eq("rst_ula_sel", 32'(ula_sel), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [CNT_WIDTH-1:0] cnt_before;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_a      = '0;
        in_b      = '0;
        in_chain  = 1'b0;
        out_ready = 1'b1;
        model_acc = '0;
        model_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Add 3+1 with latency: out_valid only after the second edge.
        send(2'b00, 4'd3, 4'd1, 1'b0);
        @(negedge clk);
        check_eq("lat_exec_valid", 32'(out_valid), 32'd0);
        check_eq("lat_exec_ready", 32'(in_ready), 32'd0);
        check_eq("lat_ula_a", 32'(ula_a), 32'd3);
        check_eq("lat_ula_b", 32'(ula_b), 32'd1);
        @(negedge clk);
        check_eq("lat_capt_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_done_valid", 32'(out_valid), 32'd1);
        check_eq("add_result", 32'(out_result), 32'd4);
        check_eq("add_zero", 32'(out_zero), 32'd0);
        @(posedge clk);
        #1;
        check_eq("add_op_count", 32'(op_count), 32'd1);
        check_eq("add_in_ready", 32'(in_ready), 32'd1);

        // Wraparound add and subtract.
        send(2'b00, 4'd15, 4'd2, 1'b0);
        wait_out(1'b1);
        check_eq("add_wrap", 32'(out_result), 32'd1);
        send(2'b01, 4'd7, 4'd8, 1'b0);
        wait_out(1'b1);
        check_eq("sub_wrap", 32'(out_result), 32'd15);

        // Chaining through the accumulator.
        send(2'b00, 4'd3, 4'd1, 1'b0);
        wait_out(1'b1);
        send(2'b10, 4'd9, 4'd1, 1'b1);
        @(negedge clk);
        check_eq("chain_ula_a", 32'(ula_a), 32'd4);
        wait_out(1'b1);
        check_eq("chain_shr", 32'(out_result), 32'd2);
        send(2'b01, 4'd0, 4'd2, 1'b1);
        wait_out(1'b1);
        check_eq("chain_sub_zero", 32'(out_result), 32'd0);
        check_eq("chain_zero_flag", 32'(out_zero), 32'd1);
        check_eq("count_after_chain", 32'(op_count), 32'(model_cnt));

        // Backpressure with a competing request held by the source.
        out_ready = 1'b0;
        send(2'b00, 4'd5, 4'd6, 1'b0);
        wait_out(1'b0);
        @(posedge clk);
        #1;
        cnt_before = op_count;
        in_sel   = 2'b11;
        in_a     = 4'd1;
        in_b     = 4'd7;
        in_chain = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_result", 32'(out_result), 32'd11);
            check_eq("bp_acc", 32'(acc), 32'd11);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_ula_b_held", 32'(ula_b), 32'd6);
            check_eq("bp_ula_sel_held", 32'(ula_sel), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_count_inc", 32'(op_count), 32'(cnt_before + 1'b1));
        check_eq("bp_in_ready_back", 32'(in_ready), 32'd1);
        check_eq("bp_ula_a_kept", 32'(ula_a), 32'd5);
        @(posedge clk);
        #1;
        check_eq("bp_count_once", 32'(op_count), 32'(cnt_before + 1'b1));

        // Shift amounts at or beyond the width.
        send(2'b11, 4'd1, 4'd7, 1'b0);
        wait_out(1'b1);
        check_eq("shl_big", 32'(out_result), 32'd0);
        send(2'b10, 4'd15, 4'd4, 1'b0);
        wait_out(1'b1);
        check_eq("shr_width", 32'(out_result), 32'd0);
        send(2'b11, 4'd3, 4'd2, 1'b0);
        wait_out(1'b1);
        check_eq("shl_wrap", 32'(out_result), 32'd12);

        // Reset while in EXEC discards the operation.
        send(2'b00, 4'd1, 4'd1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_acc = '0;
        model_cnt = '0;
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_acc", 32'(acc), 32'd0);
        check_eq("midrst_count", 32'(op_count), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("midrst_no_result", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(2'b00, 4'd9, 4'd3, 1'b1);
        wait_out(1'b1);
        check_eq("chain_after_rst", 32'(out_result), 32'd3);

        // 256 random operations wrap the counter back to zero.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            send(2'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom),
                 1'($urandom_range(0, 1)));
            wait_out(1'b1);
        end
        check_eq("count_wrap", 32'(op_count), 32'd0);
        check_eq("count_model", 32'(op_count), 32'(model_cnt));
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
